// File: rtl/hazard_scoreboard_unit_pkg.sv
// hazard_scoreboard_unit_pkg: shared sizes, default latencies and latency-select types for the ID-stage scoreboard.
package hazard_scoreboard_unit_pkg;

    localparam int REG_COUNT_D  = 16;
    localparam int REG_ADDR_W_D = 4;
    localparam int LOAD_LAT_D   = 1;
    localparam int NOFWD_LAT_D  = 2;
    localparam int CNT_W_D      = 2;
    localparam int PERF_W_D     = 16;

    typedef enum logic [1:0] {
        LAT_NONE,
        LAT_LOAD,
        LAT_NOFWD
    } lat_sel_e;

    // Forwarding hides ALU results entirely; only loads still need a gap.
    function automatic lat_sel_e pick_lat(input logic fwd_en, input logic mem_read);
        return fwd_en ? (mem_read ? LAT_LOAD : LAT_NONE) : LAT_NOFWD;
    endfunction

endpackage

// File: rtl/hazard_sb_entry.sv
// hazard_sb_entry: one scoreboard slot, a saturating down-counter that reloads with max(drained count, load_val).
module hazard_sb_entry
    import hazard_scoreboard_unit_pkg::*;
#(
    parameter int CNT_W = CNT_W_D
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_en,
    input  logic [CNT_W-1:0] load_val,
    output logic             busy
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] dec;

    assign dec  = (cnt == '0) ? '0 : cnt - CNT_W'(1);
    assign busy = |cnt;

    // A younger write never shortens an older producer's remaining distance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= (load_en && load_val > dec) ? load_val : dec;
    end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit: per-register scoreboard of in-flight writes driving the ID-stage stall, plus a stall-cycle counter.
module hazard_scoreboard_unit
    import hazard_scoreboard_unit_pkg::*;
#(
    parameter int REG_COUNT  = REG_COUNT_D,
    parameter int REG_ADDR_W = REG_ADDR_W_D,
    parameter int LOAD_LAT   = LOAD_LAT_D,
    parameter int NOFWD_LAT  = NOFWD_LAT_D,
    parameter int CNT_W      = CNT_W_D,
    parameter int PERF_W     = PERF_W_D
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fwd_en,
    input  logic                  id_valid,
    input  logic                  flush,
    input  logic                  two_src,
    input  logic [REG_ADDR_W-1:0] src1,
    input  logic [REG_ADDR_W-1:0] src2,
    input  logic [REG_ADDR_W-1:0] dest,
    input  logic                  wb_en,
    input  logic                  mem_read,
    output logic                  hazard,
    output logic [REG_COUNT-1:0]  pending,
    output logic [PERF_W-1:0]     stall_cnt
);

    logic [2**REG_ADDR_W-1:0] busy_all;
    logic                     src_busy;
    logic                     issue;
    lat_sel_e                 lat_sel;
    logic [CNT_W-1:0]         lat;

    // Indices past REG_COUNT read as permanently idle.
    always_comb begin
        busy_all                = '0;
        busy_all[REG_COUNT-1:0] = pending;
    end

    assign src_busy = busy_all[src1] | (two_src & busy_all[src2]);
    assign hazard   = id_valid & ~flush & src_busy;
    assign issue    = id_valid & ~flush & ~hazard & wb_en;
    assign lat_sel  = pick_lat(fwd_en, mem_read);
    assign lat      = (lat_sel == LAT_LOAD)  ? CNT_W'(LOAD_LAT)  :
                      (lat_sel == LAT_NOFWD) ? CNT_W'(NOFWD_LAT) : '0;

    for (genvar r = 0; r < REG_COUNT; r++) begin : g_entry
        hazard_sb_entry #(
            .CNT_W(CNT_W)
        ) u_entry (
            .clk     (clk),
            .rst_n   (rst_n),
            .load_en (issue && lat != '0 && dest == REG_ADDR_W'(r)),
            .load_val(lat),
            .busy    (pending[r])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (hazard && !(&stall_cnt))
            stall_cnt <= stall_cnt + PERF_W'(1);
    end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb_hazard_scoreboard_unit: directed and random stimulus against a ready-time model of the scoreboard.
module tb_hazard_scoreboard_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fwd_en, id_valid, flush, two_src, wb_en, mem_read;
    logic [3:0]  src1, src2, dest;
    logic        hazard, hazard_s;
    logic [15:0] pending, pending_s;
    logic [15:0] stall_cnt;
    logic [1:0]  stall_cnt_s;

    int     vectors = 0;
    int     miscompares = 0;
    longint ready [16];
    longint now = 0;
    int     sc = 0;
    int     sc2 = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_unit dut (
        .clk(clk), .rst_n(rst_n), .fwd_en(fwd_en), .id_valid(id_valid), .flush(flush),
        .two_src(two_src), .src1(src1), .src2(src2), .dest(dest), .wb_en(wb_en),
        .mem_read(mem_read), .hazard(hazard), .pending(pending), .stall_cnt(stall_cnt)
    );

    hazard_scoreboard_unit #(.PERF_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .fwd_en(fwd_en), .id_valid(id_valid), .flush(flush),
        .two_src(two_src), .src1(src1), .src2(src2), .dest(dest), .wb_en(wb_en),
        .mem_read(mem_read), .hazard(hazard_s), .pending(pending_s), .stall_cnt(stall_cnt_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // A register is busy while its write-ready cycle lies in the future.
    function automatic bit mbusy(input logic [3:0] x);
        return ready[x] > now;
    endfunction

    task automatic model_reset();
        foreach (ready[r]) ready[r] = 0;
        sc  = 0;
        sc2 = 0;
    endtask

    task automatic step(input logic v, input logic fl, input logic ts, input logic [3:0] s1,
                        input logic [3:0] s2, input logic [3:0] d, input logic wb,
                        input logic mr, input logic fe, output bit dut_hz);
        bit          hz;
        logic [15:0] ep;
        longint      lat;
        id_valid = v; flush = fl; two_src = ts; src1 = s1; src2 = s2; dest = d;
        wb_en = wb; mem_read = mr; fwd_en = fe;
        @(negedge clk);
        hz = v && !fl && (mbusy(s1) || (ts && mbusy(s2)));
        for (int r = 0; r < 16; r++) ep[r] = ready[r] > now;
        check("hazard", {31'b0, hazard}, {31'b0, hz});
        check("hazard_p2", {31'b0, hazard_s}, {31'b0, hz});
        check("pending", {16'b0, pending}, {16'b0, ep});
        check("stall_cnt", {16'b0, stall_cnt}, sc);
        check("stall_cnt_p2", {30'b0, stall_cnt_s}, sc2);
        dut_hz = hazard;
        @(posedge clk);
        if (hz) begin
            if (sc < 65535) sc++;
            if (sc2 < 3) sc2++;
        end
        lat = fe ? (mr ? 1 : 0) : 2;
        if (v && !fl && !hz && wb && lat > 0 && now + 1 + lat > ready[d]) ready[d] = now + 1 + lat;
        now++;
        #1;
    endtask

    // Holds one consumer in ID until the DUT releases it and checks the stall length.
    task automatic consume(input string tag, input logic ts, input logic [3:0] s1,
                           input logic [3:0] s2, input logic [3:0] d, input logic wb,
                           input logic fe, input int exp);
        bit dh;
        int n = 0;
        bit done = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            step(1, 0, ts, s1, s2, d, wb, 0, fe, dh);
            if (dh) n++;
            else done = 1;
        end
        if (!done) check({tag, "_timeout"}, 0, 1);
        check(tag, n, exp);
    endtask

    initial begin
        bit dh;
        rst_n = 1'b0;
        {fwd_en, id_valid, flush, two_src, wb_en, mem_read} = '0;
        src1 = '0; src2 = '0; dest = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_state_hazard", {31'b0, hazard}, 0);
        check("rst_state_pending", {16'b0, pending}, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, dh);

        step(1, 0, 0, 0, 0, 3, 1, 1, 1, dh);
        consume("load_use", 0, 3, 0, 4, 1, 1, 1);
        check("stall_cnt_load", {16'b0, stall_cnt}, 1);

        step(1, 0, 0, 0, 0, 5, 1, 0, 0, dh);
        consume("nofwd_src2", 1, 0, 5, 6, 1, 0, 2);
        step(1, 0, 0, 0, 0, 5, 1, 0, 0, dh);
        consume("src1_only", 0, 1, 5, 9, 0, 0, 0);

        step(1, 0, 0, 0, 0, 2, 1, 0, 0, dh);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, dh);
        step(1, 0, 0, 0, 0, 2, 1, 0, 0, dh);
        consume("reload_r2", 0, 2, 0, 0, 0, 0, 2);

        step(1, 1, 0, 0, 0, 7, 1, 1, 1, dh);
        check("flush_pend7", {31'b0, pending[7]}, 0);
        consume("flush_r7", 0, 7, 0, 0, 0, 1, 0);

        check("perf_total", {16'b0, stall_cnt}, 5);
        check("perf_sat", {30'b0, stall_cnt_s}, 3);

        step(1, 0, 0, 0, 0, 8, 1, 1, 1, dh);
        consume("toggle_fwd", 0, 8, 0, 10, 1, 0, 1);

        step(1, 0, 0, 0, 0, 3, 1, 0, 0, dh);
        id_valid = 1; flush = 0; two_src = 0; src1 = 3; wb_en = 0; fwd_en = 0;
        #2 check("pre_rst_hazard", {31'b0, hazard}, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_hazard", {31'b0, hazard}, 0);
        check("midrst_pending", {16'b0, pending}, 0);
        check("midrst_stall", {16'b0, stall_cnt}, 0);
        check("midrst_stall_p2", {30'b0, stall_cnt_s}, 0);
        model_reset();
        @(posedge clk);
        now++;
        #1 rst_n = 1'b1;
        consume("post_rst", 0, 3, 0, 0, 0, 0, 0);

        for (int i = 0; i < 600; i++) begin
            logic [3:0] s1, s2, d;
            logic fe;
            s1 = ($urandom % 4 == 0) ? 4'($urandom) : 4'($urandom % 5);
            s2 = ($urandom % 4 == 0) ? 4'($urandom) : 4'($urandom % 5);
            d  = ($urandom % 4 == 0) ? 4'($urandom) : 4'($urandom % 5);
            fe = ($urandom % 3 != 0);
            step($urandom % 8 != 0, $urandom % 8 == 0, 1'($urandom), s1, s2, d,
                 $urandom % 4 != 0, $urandom % 3 == 0, fe, dh);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
